// File: rtl/bk_pkg.sv
// Shared types for the backup-RAM sector sequencer.
package bk_pkg;

    localparam int unsigned SECT_BITS_DEF = 4;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        XFER,
        NEXT
    } bk_state_e;

    typedef enum logic {
        JOB_RD,
        JOB_WR
    } bk_job_e;

endpackage

// File: rtl/bk_edge_det.sv
// Registered rising/falling edge detector. The history register always tracks the input,
// so a level already high when reset is released never reports a rising edge.
module bk_edge_det (
    input  logic clk,
    input  logic d,
    output logic rise,
    output logic fall
);

    logic d_q;

    always_ff @(posedge clk) begin
        d_q <= d;
    end

    assign rise = d & ~d_q;
    assign fall = ~d & d_q;

endmodule

// File: rtl/bk_sector_ctrl.sv
// Backup-RAM sector sequencer: moves the nvram buffer to/from the SAV image one SD sector at
// a time, with mount-triggered load, OSD-triggered save, dirty tracking and download abort.
module bk_sector_ctrl #(
    parameter int unsigned SECT_BITS = bk_pkg::SECT_BITS_DEF,
    parameter int unsigned LBA_W     = 32
) (
    input  logic             clk_sys,
    input  logic             RESET_n,
    input  logic             img_mounted,
    input  logic [31:0]      img_size,
    input  logic             ioctl_download,
    input  logic             save_req,
    input  logic             nvram_we,
    input  logic             sd_ack,
    output logic [LBA_W-1:0] sd_lba,
    output logic             sd_rd,
    output logic             sd_wr,
    output logic             bk_ena,
    output logic             bk_busy,
    output logic             bk_reset,
    output logic             dirty
);
    import bk_pkg::*;

    logic mnt_rise, save_rise, dl_rise, ack_rise, ack_fall;
    logic unused_mnt_fall, unused_save_fall, unused_dl_fall;

    bk_edge_det u_mnt_edge (
        .clk  (clk_sys),
        .d    (img_mounted),
        .rise (mnt_rise),
        .fall (unused_mnt_fall)
    );

    bk_edge_det u_save_edge (
        .clk  (clk_sys),
        .d    (save_req),
        .rise (save_rise),
        .fall (unused_save_fall)
    );

    bk_edge_det u_dl_edge (
        .clk  (clk_sys),
        .d    (ioctl_download),
        .rise (dl_rise),
        .fall (unused_dl_fall)
    );

    bk_edge_det u_ack_edge (
        .clk  (clk_sys),
        .d    (sd_ack),
        .rise (ack_rise),
        .fall (ack_fall)
    );

    bk_state_e        state_q, state_d;
    bk_job_e          dir_q, dir_d;
    logic [LBA_W-1:0] lba_q, lba_d;
    logic             ena_q, ena_d;
    logic             reset_q, reset_d;
    logic             dirty_q, dirty_d;
    logic             load_pend_q, load_pend_d;
    logic             save_pend_q, save_pend_d;
    logic             abort_q, abort_d;
    logic             last_sect;
    logic             loading;

    assign last_sect = &lba_q[SECT_BITS-1:0];
    assign loading   = (state_q != IDLE) && (dir_q == JOB_RD);

    always_comb begin
        state_d     = state_q;
        dir_d       = dir_q;
        lba_d       = lba_q;
        ena_d       = ena_q;
        reset_d     = 1'b0;
        dirty_d     = dirty_q;
        load_pend_d = load_pend_q;
        save_pend_d = save_pend_q;
        abort_d     = abort_q | dl_rise;

        unique case (state_q)
            IDLE: begin
                abort_d = 1'b0;
                // A download starting this cycle holds off the grant so nothing is issued.
                if (!dl_rise && (load_pend_q || (save_pend_q && ena_q))) begin
                    state_d = REQ;
                    lba_d   = '0;
                    if (load_pend_q) begin
                        dir_d       = JOB_RD;
                        load_pend_d = 1'b0;
                    end else begin
                        dir_d       = JOB_WR;
                        save_pend_d = 1'b0;
                        dirty_d     = 1'b0;
                    end
                end
            end
            REQ: begin
                if (ack_rise) state_d = XFER;
            end
            XFER: begin
                if (ack_fall) state_d = NEXT;
            end
            NEXT: begin
                if (abort_q || dl_rise) begin
                    state_d = IDLE;
                    abort_d = 1'b0;
                end else if (last_sect) begin
                    state_d = IDLE;
                    if (dir_q == JOB_RD) begin
                        reset_d = 1'b1;
                        dirty_d = 1'b0;
                    end
                end else begin
                    lba_d   = lba_q + LBA_W'(1);
                    state_d = REQ;
                end
            end
            default: state_d = IDLE;
        endcase

        // Writes from the system side win over the clear at save start.
        if (nvram_we && !loading) dirty_d = 1'b1;

        if (save_rise && ena_q) save_pend_d = 1'b1;

        if (mnt_rise) begin
            ena_d       = (img_size != '0);
            load_pend_d = (img_size != '0);
            if (img_size == '0) save_pend_d = 1'b0;
        end

        if (dl_rise) begin
            ena_d       = 1'b0;
            save_pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!RESET_n) begin
            state_q     <= IDLE;
            dir_q       <= JOB_RD;
            lba_q       <= '0;
            ena_q       <= 1'b0;
            reset_q     <= 1'b0;
            dirty_q     <= 1'b0;
            load_pend_q <= 1'b0;
            save_pend_q <= 1'b0;
            abort_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            dir_q       <= dir_d;
            lba_q       <= lba_d;
            ena_q       <= ena_d;
            reset_q     <= reset_d;
            dirty_q     <= dirty_d;
            load_pend_q <= load_pend_d;
            save_pend_q <= save_pend_d;
            abort_q     <= abort_d;
        end
    end

    assign sd_lba   = lba_q;
    assign sd_rd    = (state_q == REQ) && (dir_q == JOB_RD);
    assign sd_wr    = (state_q == REQ) && (dir_q == JOB_WR);
    assign bk_ena   = ena_q;
    assign bk_busy  = (state_q != IDLE);
    assign bk_reset = reset_q;
    assign dirty    = dirty_q;

endmodule

// File: doc/bk_sector_ctrl.md
Name: bk_sector_ctrl

Overview:
Sequences backup-RAM (cartridge save RAM) transfers between the on-chip nvram dual-port buffer and the mounted SAV image, one 512-byte sector at a time over the user_io SD handshake. It handles mount-triggered load, OSD-triggered save, dirty tracking, download abort and the post-load system reset pulse. It sits in the top level between user_io (sd_* signals), the nvram dpram port B (address from sd_lba low bits) and the system reset/LED logic.

Parameters:
SECT_BITS, 4, log2 of sectors per transfer (16 sectors = 8 KB nvram)
LBA_W, 32, width of sd_lba

Ports:
clk_sys  in  1  system clock
RESET_n  in  1  synchronous active-low reset
img_mounted  in  1  level from user_io; rising edge = new image mounted
img_size  in  32  size of the mounted image in bytes
ioctl_download  in  1  ROM download in progress
save_req  in  1  OSD "Write Save RAM" level; rising edge = save request
nvram_we  in  1  system-side write strobe to nvram (dirty tracking)
sd_ack  in  1  user_io sector transfer acknowledge
sd_lba  out  LBA_W  sector address; low SECT_BITS also index nvram port B
sd_rd  out  1  sector read request
sd_wr  out  1  sector write request
bk_ena  out  1  valid save image mounted
bk_busy  out  1  transfer in progress (drives LED off)
bk_reset  out  1  one-cycle pulse after a completed load
dirty  out  1  nvram modified since last load/save start

Behaviour:
- Reset (RESET_n=0 at clk edge): state IDLE; sd_lba=0, sd_rd=0, sd_wr=0, bk_ena=0, bk_busy=0, bk_reset=0, dirty=0, pending_save=0; edge registers load current input values, so a level already high at reset release does not trigger.
- Edge detect: img_mounted, save_req, ioctl_download and sd_ack are registered once; rising/falling edges are decoded against the registered copy.
- Mount rising edge: img_size!=0 -> bk_ena=1 and load_pending=1; img_size==0 -> bk_ena=0 and no transfer.
- Download rising edge: bk_ena=0, pending_save=0. If a transfer is active, the current sector completes normally (the SD handshake is never abandoned), then the FSM goes to IDLE. No further sectors are issued and no bk_reset is generated.
- Save rising edge: sets pending_save if bk_ena=1, otherwise ignored. When busy, the request stays pending and starts when IDLE is re-entered.
- Priority in IDLE: load_pending over pending_save. Both set -> load runs first, then save.
- FSM states: IDLE, REQ, XFER, NEXT.
  - IDLE -> REQ on a granted job (load: dir=rd, clears load_pending; save: dir=wr, clears pending_save and dirty). Sets sd_lba=0 and bk_busy=1.
  - REQ: sd_rd=dir_rd, sd_wr=~dir_rd. The first request is asserted in the cycle after the grant. On the sd_ack rising edge, sd_rd and sd_wr are cleared in the same cycle -> XFER.
  - XFER: on the sd_ack falling edge -> NEXT.
  - NEXT (1 cycle): if aborted -> IDLE, bk_busy=0. Else if sd_lba[SECT_BITS-1:0] is all ones -> IDLE, bk_busy=0, and for a load also bk_reset=1 for one cycle and dirty=0. Else sd_lba increments by 1 (upper bits stay 0) -> REQ.
- sd_lba is stable from request assertion until the ack falls.
- Exactly 2^SECT_BITS requests per job. sd_rd and sd_wr are never both high.
- dirty: set by nvram_we in any state except during a load; the clear on save start loses to a same-cycle nvram_we (set wins). nvram_we during a save sets dirty again.
- A new mount edge during a transfer sets load_pending. It runs after the current job; bk_ena is updated immediately.
- No timeouts: the FSM waits on sd_ack indefinitely. Only RESET_n recovers it.

Decomposition:
- Package bk_pkg: state enum (IDLE, REQ, XFER, NEXT), the SECT_BITS default, and a job-direction typedef (JOB_RD, JOB_WR).
- One sub-module, bk_edge_det: a registered rising/falling edge detector, instantiated for each of the four monitored inputs.
- The FSM stays in bk_sector_ctrl.

Test Plan:
- Mount with img_size=8192; ack model responds 3 cycles after the request with a 5-cycle-wide ack -> 16 sd_rd pulses at lba 0..15, bk_reset pulses once after the lba-15 ack falls, bk_ena=1, bk_busy low afterwards.
- After the load, nvram_we pulse then save_req rise -> dirty=1, then 0 at save start; 16 sd_wr pulses at lba 0..15; no bk_reset.
- save_req rises during the load at lba 5 -> the load finishes (bk_reset pulses), then the save starts in the cycle after the lba-15 NEXT, running 16 writes.
- ioctl_download rises while in XFER at lba 7 -> the lba-7 ack completes, no lba-8 request, bk_ena=0, bk_reset never pulses.
- Mount with img_size=0 -> no sd_rd, bk_ena=0; a later save_req is ignored.
- RESET_n low while in REQ at lba 3 -> next cycle all outputs 0, state IDLE; img_mounted still high at release causes no transfer.
